// File: rtl/sub_32bit_seq.sv
// Digit-serial 32-bit subtractor: A - B is formed DIGIT_W bits per clock as A + ~B + 1.
// Borrow-out and two's-complement overflow are published together with the difference.
module sub_32bit_seq #(
    parameter int DIGIT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [32:1] A,
    input  logic [32:1] B,
    output logic [32:1] D,
    output logic        B32,
    output logic        V,
    output logic        busy,
    output logic        done
);

    localparam int N     = 32 / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [32:1]        a_r;
    logic [32:1]        b_r;
    logic [32:1]        work_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic [32:1]        d_r;
    logic               b32_r;
    logic               v_r;
    logic               busy_r;
    logic               done_r;

    logic [5:0]         base_s;
    logic [DIGIT_W-1:0] a_dig_s;
    logic [DIGIT_W-1:0] b_dig_s;
    logic [DIGIT_W:0]   sum_s;
    logic [32:1]        work_next_s;
    logic               last_s;
    logic               v_s;

    // Digit adder: the working register with the current digit merged in is what D loads on the last digit.
    always_comb begin
        base_s      = 6'(cnt_r) * 6'(DIGIT_W);
        a_dig_s     = a_r[base_s + 6'd1 +: DIGIT_W];
        b_dig_s     = b_r[base_s + 6'd1 +: DIGIT_W];
        sum_s       = {1'b0, a_dig_s} + {1'b0, ~b_dig_s} + (DIGIT_W + 1)'(carry_r);
        work_next_s = work_r;
        work_next_s[base_s + 6'd1 +: DIGIT_W] = sum_s[DIGIT_W-1:0];
        last_s      = (cnt_r == CNT_LAST);
        v_s         = (a_r[32] != b_r[32]) & (work_next_s[32] != a_r[32]);
    end

    // Next-state logic for IDLE -> RUN (N digits) -> DONE -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == S_RUN);
            done_r  <= (state_next_s == S_DONE);
        end
    end

    // Operand capture, digit iteration and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            work_r  <= 32'd0;
            cnt_r   <= CNT_ZERO;
            carry_r <= 1'b1;
            d_r     <= 32'd0;
            b32_r   <= 1'b0;
            v_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        a_r     <= A;
                        b_r     <= B;
                        work_r  <= 32'd0;
                        cnt_r   <= CNT_ZERO;
                        carry_r <= 1'b1;
                    end
                end
                S_RUN: begin
                    work_r  <= work_next_s;
                    carry_r <= sum_s[DIGIT_W];
                    if (last_s) begin
                        // Results change only here, so D never shows a partial difference.
                        cnt_r <= CNT_ZERO;
                        d_r   <= work_next_s;
                        b32_r <= ~sum_s[DIGIT_W];
                        v_r   <= v_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_DONE: begin
                    cnt_r <= CNT_ZERO;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign D    = d_r;
    assign B32  = b32_r;
    assign V    = v_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
